// File: rtl/ad9361_ctrl_regs.sv
// ad9361_ctrl_regs: register slave driving the AD9361 control pins.
// Timed self-clearing reset sequence (IDLE -> ASSERT -> SETTLE -> READY),
// gated ENABLE, TXNRX and a general-purpose CTRL_IN bank, full readback.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   en, wen, addr, din         register bus access (en qualifies, wen=1 write)
//   dout                       registered read data, held until next read
//   ad9361_rstb                RESETB, low while the sequence is in ASSERT
//   ad9361_en                  ENABLE, en register gated by READY
//   ad9361_txnrx, ad9361_ctrl  TXNRX and CTRL_IN bank, follow their registers
//   busy                       high in ASSERT and SETTLE
//   irq                        sticky READY-entry flag (AD9361_CTRL_IRQ_EN only)
//
// Optional feature macro: AD9361_CTRL_IRQ_EN adds irq and register 0x140.
module ad9361_ctrl_regs #(
    parameter logic [17:0] BASE          = 18'h0,
    parameter int unsigned CTRL_W        = 4,
    parameter int unsigned RST_CYCLES    = 1000,
    parameter int unsigned SETTLE_CYCLES = 4096,
    parameter int unsigned POR_SEQ       = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wen,
    input  logic [17:0]       addr,
    input  logic [31:0]       din,
    output logic [31:0]       dout,
    output logic              ad9361_rstb,
    output logic              ad9361_en,
    output logic              ad9361_txnrx,
    output logic [CTRL_W-1:0] ad9361_ctrl,
`ifdef AD9361_CTRL_IRQ_EN
    output logic              irq,
`endif
    output logic              busy
);

    localparam int unsigned MAX_CYC = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_W   = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

    localparam logic [17:0] A_RST    = BASE + 18'h100;
    localparam logic [17:0] A_EN     = BASE + 18'h110;
    localparam logic [17:0] A_TXNRX  = BASE + 18'h114;
    localparam logic [17:0] A_CTRL   = BASE + 18'h120;
    localparam logic [17:0] A_STATUS = BASE + 18'h130;
`ifdef AD9361_CTRL_IRQ_EN
    localparam logic [17:0] A_IRQ    = BASE + 18'h140;
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ASSERT = 2'd1,
        S_SETTLE = 2'd2,
        S_READY  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               por_pend;
    logic               en_reg, en_reg_nxt;
    logic               txnrx_nxt;
    logic [CTRL_W-1:0]  ctrl_nxt;
    logic [31:0]        rdata, dout_nxt;
    logic               rstb_nxt, aden_nxt, busy_nxt;
    logic               wr, rd, start;
`ifdef AD9361_CTRL_IRQ_EN
    logic               irq_nxt;
`endif

    // Write data bits beyond the widest register are architecturally ignored.
    logic unused_din;
    assign unused_din = ^din[31:1];

    // Next-state, register updates, read mux and pin values.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        en_reg_nxt = en_reg;
        txnrx_nxt  = ad9361_txnrx;
        ctrl_nxt   = ad9361_ctrl;
        rdata      = 32'h0;
        wr         = en & wen;
        rd         = en & ~wen;
        start      = wr && (addr == A_RST) && din[0];

        // Counter loads N-1 on entry so each timed state lasts exactly N cycles.
        case (state)
            S_IDLE: begin
                if (por_pend || start) begin
                    state_nxt = S_ASSERT;
                    cnt_nxt   = CNT_W'(RST_CYCLES - 1);
                end
            end
            S_ASSERT: begin
                if (cnt == '0) begin
                    state_nxt = S_SETTLE;
                    cnt_nxt   = CNT_W'(SETTLE_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_SETTLE: begin
                if (cnt == '0) begin
                    state_nxt = S_READY;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            S_READY: begin
                if (start) begin
                    state_nxt = S_ASSERT;
                    cnt_nxt   = CNT_W'(RST_CYCLES - 1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (wr) begin
            if (addr == A_EN)    en_reg_nxt = din[0];
            if (addr == A_TXNRX) txnrx_nxt  = din[0];
            if (addr == A_CTRL)  ctrl_nxt   = din[CTRL_W-1:0];
        end

`ifdef AD9361_CTRL_IRQ_EN
        // Set on READY entry has priority over a same-cycle clear.
        irq_nxt = irq;
        if ((state_nxt == S_READY) && (state != S_READY)) begin
            irq_nxt = 1'b1;
        end else if (wr && (addr == A_IRQ) && din[0]) begin
            irq_nxt = 1'b0;
        end
`endif

        case (addr)
            A_RST:    rdata = {30'h0, busy, (state == S_READY)};
            A_EN:     rdata = {31'h0, en_reg};
            A_TXNRX:  rdata = {31'h0, ad9361_txnrx};
            A_CTRL:   rdata = 32'(ad9361_ctrl);
            A_STATUS: rdata = {state, 30'(cnt)};
`ifdef AD9361_CTRL_IRQ_EN
            A_IRQ:    rdata = {31'h0, irq};
`endif
            default:  rdata = 32'h0;
        endcase

        dout_nxt = rd ? rdata : dout;
        rstb_nxt = (state_nxt != S_ASSERT);
        busy_nxt = (state_nxt == S_ASSERT) || (state_nxt == S_SETTLE);
        aden_nxt = en_reg_nxt && (state_nxt == S_READY);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            por_pend     <= (POR_SEQ != 0);
            en_reg       <= 1'b0;
            ad9361_txnrx <= 1'b0;
            ad9361_ctrl  <= '0;
            dout         <= 32'h0;
            ad9361_rstb  <= 1'b1;
            ad9361_en    <= 1'b0;
            busy         <= 1'b0;
`ifdef AD9361_CTRL_IRQ_EN
            irq          <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            por_pend     <= 1'b0;
            en_reg       <= en_reg_nxt;
            ad9361_txnrx <= txnrx_nxt;
            ad9361_ctrl  <= ctrl_nxt;
            dout         <= dout_nxt;
            ad9361_rstb  <= rstb_nxt;
            ad9361_en    <= aden_nxt;
            busy         <= busy_nxt;
`ifdef AD9361_CTRL_IRQ_EN
            irq          <= irq_nxt;
`endif
        end
    end

endmodule

// File: doc/ad9361_ctrl_regs.md
Name: ad9361_ctrl_regs

Overview:
- Parametrised successor of the AD9361 reset/enable register slave on the PS-side register bus.
- Adds timed, self-clearing reset sequencing, settle delay, a parametrised general-purpose control bank, TXNRX control and full register readback.
- Sits between the register decode fabric and the AD9361 control pins (RESETB, ENABLE, TXNRX, CTRL_IN).

Parameters:
- BASE, 18'h0, register window base; every register address is BASE + offset.
- CTRL_W, 4, width of general-purpose control output bank (1..32).
- RST_CYCLES, 1000, clk cycles RESETB is held low per reset sequence (>=1).
- SETTLE_CYCLES, 4096, clk cycles after RESETB release before READY (>=1).
- POR_SEQ, 1, 1: run the reset sequence automatically on leaving reset; 0: stay IDLE with RESETB high.

Ports:
- clk  in  1  register/bus clock.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  bus select, qualifies access this cycle.
- wen  in  1  1 = write, 0 = read (valid when en=1).
- addr  in  18  byte address.
- din  in  32  write data.
- dout  out  32  read data, registered.
- ad9361_rstb  out  1  AD9361 RESETB, active-low.
- ad9361_en  out  1  AD9361 ENABLE.
- ad9361_txnrx  out  1  AD9361 TXNRX.
- ad9361_ctrl  out  CTRL_W  AD9361 CTRL_IN bank.
- busy  out  1  reset sequence in progress.

Behaviour:
- Register map (offset, access):
  - 0x100 RST, W: bit0=1 starts sequence; R: {30'b0, busy, ready}.
  - 0x110 EN, R/W bit0 = en_reg.
  - 0x114 TXNRX, R/W bit0.
  - 0x120 CTRL, R/W bits [CTRL_W-1:0]; upper read bits zero.
  - 0x130 STATUS, RO: {state[1:0] in bits 31:30, zero, counter value in low bits}.
- Unmapped addresses: writes ignored, reads return 32'h0.
- Read: en=1, wen=0 at cycle N -> dout valid at cycle N+1, held until the next read; writes do not change dout.
- FSM states: IDLE, ASSERT, SETTLE, READY.
  - IDLE: rstb=1. Goes to ASSERT on RST write with bit0=1.
  - ASSERT: rstb=0, counter loaded to RST_CYCLES-1 on entry, decrements each cycle. Goes to SETTLE on count 0; ASSERT lasts exactly RST_CYCLES cycles.
  - SETTLE: rstb=1, lasts exactly SETTLE_CYCLES cycles, then READY.
  - READY: rstb=1, ready=1. RST write with bit0=1 goes back to ASSERT.
- busy=1 in ASSERT and SETTLE.
- Output gating:
  - ad9361_en = en_reg & (state==READY); en_reg is stored while busy but takes effect only in READY.
  - ad9361_txnrx and ad9361_ctrl follow their registers in all states.
- RST writes while busy are ignored and do not restart the sequence.
- RST write with bit0=0 is a no-op.
- Counter width is $clog2 of the larger of RST_CYCLES and SETTLE_CYCLES, minimum 1.
- Async reset (rst_n low): en_reg=0, txnrx=0, ctrl=0, dout=0, counter=0.
  - State is forced to IDLE and rstb=1 while rst_n is low.
  - On rst_n release with POR_SEQ=1, the first clk edge enters ASSERT. With POR_SEQ=0, the block stays in IDLE.
- Reset mid-sequence aborts immediately. No partial state survives.
- Simultaneous read and write cannot occur (single bus), so no arbitration is required.

Optional Feature:
- Macro AD9361_CTRL_IRQ_EN.
- Defined:
  - Adds output port irq (1 bit) and register 0x140 IRQ.
  - irq is a sticky flag set on the cycle the FSM enters READY.
  - Reading 0x140 returns {31'b0, irq}. Writing 0x140 with bit0=1 clears it.
  - If set and clear land on the same cycle, set wins.
  - irq resets to 0.
- Undefined: no irq port; 0x140 is unmapped and reads 0.

Test Plan:
- POR_SEQ=1, RST_CYCLES=4, SETTLE_CYCLES=8; release rst_n -> rstb low for exactly 4 clk, busy high for 12 clk, RST readback = 32'h1 afterwards.
- Write EN=1 while in SETTLE -> ad9361_en stays 0 until READY, then rises on the same cycle ready rises; EN readback = 1 throughout.
- Write CTRL=32'hFFFF_FFFF (CTRL_W=4) -> ad9361_ctrl=4'hF; read 0x120 -> dout=32'h0000_000F one cycle after the read.
- In READY, write RST=1, then a second RST=1 mid-ASSERT -> single sequence, total busy = RST_CYCLES+SETTLE_CYCLES; ad9361_en drops to 0 during the sequence.
- Pull rst_n low during ASSERT -> rstb=1, en=0, ctrl=0, dout=0 immediately; read unmapped 0x1FC -> 32'h0.
- With AD9361_CTRL_IRQ_EN: sequence completes -> irq=1; write 0x140=1 -> irq=0 next cycle; clear on the READY-entry cycle -> irq remains 1.
